// File: rtl/game_pkg.sv
// Shared game constants, state encoding and helpers.
// Imported by the controller and other game blocks.
package game_pkg;

  localparam int OLED_WIDTH  = 96;
  localparam int OLED_HEIGHT = 64;
  localparam int OLED_PIXELS = OLED_WIDTH * OLED_HEIGHT;
  localparam int PIX_IDX_W   = 13;
  localparam int LIVES_W     = 2;
  localparam int SCORE_W     = 14;
  localparam int FCNT_W      = 8;

  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PLAYING,
    ST_GRACE,
    ST_GAME_OVER
  } game_state_e;

  function automatic logic [SCORE_W-1:0] sat_inc(
    input logic [SCORE_W-1:0] v
  );
    return (v == SCORE_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/frame_tick.sv
// One-cycle frame-end strobe: the scan index wraps
// from a nonzero value back to 0.
module frame_tick #(
  parameter int FRAME_PIXELS = 6144,
  localparam int IDX_W = $clog2(FRAME_PIXELS)
) (
  input  logic             clock_100mhz,
  input  logic             reset,
  input  logic [IDX_W-1:0] pixel_index,
  output logic             frame_end
);

  logic [IDX_W-1:0] prev_index;

  always_ff @(posedge clock_100mhz) begin
    if (reset) prev_index <= '0;
    else       prev_index <= pixel_index;
  end

  assign frame_end = (prev_index != '0) &&
                     (pixel_index == '0);

endmodule

// File: rtl/game_state_ctrl.sv
// Game flow controller: start, lives, score, grace
// period after a hit and timed game-over hold.
module game_state_ctrl
  import game_pkg::*;
#(
  parameter int LIVES_INIT   = 3,
  parameter int GRACE_FRAMES = 60,
  parameter int OVER_FRAMES  = 120,
  parameter int FRAME_PIXELS = OLED_PIXELS
) (
  input  logic                 clock_100mhz,
  input  logic                 reset,
  input  logic                 btnC,
  input  logic [PIX_IDX_W-1:0] pixel_index,
  input  logic                 is_player_hitbox,
  input  logic                 is_obstacle_hitbox,
  output logic                 game_active,
  output logic [LIVES_W-1:0]   lives,
  output logic [SCORE_W-1:0]   score,
  output logic                 collision_pulse,
  output logic                 game_over
);

  game_state_e       state;
  logic              btn_q;
  logic              hit_flag;
  logic [FCNT_W-1:0] grace_cnt;
  logic [FCNT_W-1:0] over_cnt;
  logic              frame_end;
  logic              btn_edge;
  logic              overlap;
  logic              start;

  frame_tick #(
    .FRAME_PIXELS(FRAME_PIXELS)
  ) u_tick (
    .clock_100mhz(clock_100mhz),
    .reset       (reset),
    .pixel_index (pixel_index),
    .frame_end   (frame_end)
  );

  assign btn_edge = btnC & ~btn_q;
  assign overlap  = is_player_hitbox &
                    is_obstacle_hitbox;
  assign start    = btn_edge &
                    ((state == ST_IDLE) ||
                     ((state == ST_GAME_OVER) &&
                      (over_cnt == '0)));

  always_ff @(posedge clock_100mhz) begin
    if (reset) begin
      state           <= ST_IDLE;
      btn_q           <= 1'b0;
      hit_flag        <= 1'b0;
      grace_cnt       <= '0;
      over_cnt        <= '0;
      game_active     <= 1'b0;
      lives           <= '0;
      score           <= '0;
      collision_pulse <= 1'b0;
      game_over       <= 1'b0;
    end else begin
      btn_q           <= btnC;
      collision_pulse <= 1'b0;
      // overlap on the wrap cycle opens the new frame
      if (frame_end)    hit_flag <= overlap;
      else if (overlap) hit_flag <= 1'b1;

      case (state)
        ST_PLAYING: begin
          if (frame_end && hit_flag) begin
            collision_pulse <= 1'b1;
            if (lives != '0) lives <= lives - 1'b1;
            if (lives <= 1) begin
              state       <= ST_GAME_OVER;
              over_cnt    <= FCNT_W'(OVER_FRAMES);
              game_active <= 1'b0;
              game_over   <= 1'b1;
            end else begin
              state     <= ST_GRACE;
              grace_cnt <= FCNT_W'(GRACE_FRAMES);
            end
          end else if (frame_end) begin
            score <= sat_inc(score);
          end
        end
        ST_GRACE: begin
          if (frame_end) begin
            score     <= sat_inc(score);
            grace_cnt <= grace_cnt - 1'b1;
            if (grace_cnt <= 1) state <= ST_PLAYING;
          end
        end
        ST_GAME_OVER: begin
          if (frame_end && over_cnt != '0)
            over_cnt <= over_cnt - 1'b1;
        end
        default: ;
      endcase

      if (start) begin
        state       <= ST_PLAYING;
        lives       <= LIVES_W'(LIVES_INIT);
        score       <= '0;
        hit_flag    <= 1'b0;
        game_active <= 1'b1;
        game_over   <= 1'b0;
      end
    end
  end

endmodule
